prog_loader: RTL and testbench

- Byte-serial program/data loader that sits upstream of the RISC16 core.
- Receives framed bytes from a host link and assembles them into 16-bit words.
- Writes the words into the core's 256x16 instruction memory or 256x16 data memory.
- Holds the core in reset-like idle (pc frozen at 0) until a valid instruction image has been loaded.

---
 rtl/prog_loader.sv | 228 ++++++++++++++++++++++
 tb/tb_prog_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-serial loader: parses MAGIC/TARGET/BASE/COUNT frames and streams 16-bit words into instruction or data memory.
// Optional trailing XOR checksum byte enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter logic [7:0] MAGIC  = 8'hA5,
    parameter int         ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              cpu_hold,
    output logic              frame_done,
    output logic              frame_err
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_TGT  = 4'd1,
        S_BASE = 4'd2,
        S_CNT  = 4'd3,
        S_HI   = 4'd4,
        S_LO   = 4'd5,
        S_WR   = 4'd6,
        S_CSUM = 4'd7,
        S_END  = 4'd8
    } state_t;

    state_t              state_q, state_d;
    logic                wr_sel_q, wr_sel_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [8:0]          rem_q, rem_d;
    logic [7:0]          hi_q, hi_d;
    logic [7:0]          csum_q, csum_d;
    logic                in_ready_q, in_ready_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]         wr_data_q, wr_data_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                frame_done_q, frame_done_d;
    logic                frame_err_q, frame_err_d;
    logic                xfer_s;

    assign xfer_s     = in_valid & in_ready_q;
    assign in_ready   = in_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_sel     = wr_sel_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cpu_hold   = cpu_hold_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_sel_q     <= 1'b0;
            ptr_q        <= '0;
            rem_q        <= 9'd0;
            hi_q         <= 8'd0;
            csum_q       <= 8'd0;
            in_ready_q   <= 1'b1;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 16'd0;
            cpu_hold_q   <= 1'b1;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_sel_q     <= wr_sel_d;
            ptr_q        <= ptr_d;
            rem_q        <= rem_d;
            hi_q         <= hi_d;
            csum_q       <= csum_d;
            in_ready_q   <= in_ready_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cpu_hold_q   <= cpu_hold_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Next-state and frame-context update
    always_comb begin
        state_d  = state_q;
        wr_sel_d = wr_sel_q;
        ptr_d    = ptr_q;
        rem_d    = rem_q;
        hi_d     = hi_q;
        csum_d   = csum_q;
        case (state_q)
            S_IDLE: begin
                if (xfer_s && (in_data == MAGIC)) begin
                    state_d = S_TGT;
                    csum_d  = 8'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TGT: begin
                if (xfer_s) begin
                    if (in_data[7:1] == 7'd0) begin
                        wr_sel_d = in_data[0];
                        state_d  = S_BASE;
                    end else begin
                        state_d  = S_IDLE;
                    end
                end else begin
                    state_d = S_TGT;
                end
            end
            S_BASE: begin
                if (xfer_s) begin
                    ptr_d   = in_data[ADDR_W-1:0];
                    state_d = S_CNT;
                end else begin
                    state_d = S_BASE;
                end
            end
            S_CNT: begin
                if (xfer_s) begin
                    rem_d   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
                    state_d = S_HI;
                end else begin
                    state_d = S_CNT;
                end
            end
            S_HI: begin
                if (xfer_s) begin
                    hi_d    = in_data;
                    csum_d  = csum_q ^ in_data;
                    state_d = S_LO;
                end else begin
                    state_d = S_HI;
                end
            end
            S_LO: begin
                if (xfer_s) begin
                    csum_d  = csum_q ^ in_data;
                    state_d = S_WR;
                end else begin
                    state_d = S_LO;
                end
            end
            S_WR: begin
                ptr_d = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                rem_d = rem_q - 9'd1;
                if (rem_q == 9'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_END;
`endif
                end else begin
                    state_d = S_HI;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer_s) begin
                    state_d = (in_data == csum_q) ? S_END : S_IDLE;
                end else begin
                    state_d = S_CSUM;
                end
            end
`endif
            S_END:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Registered output values, derived from the upcoming state
    always_comb begin
        in_ready_d   = !((state_d == S_WR) || (state_d == S_END));
        wr_en_d      = (state_d == S_WR);
        frame_done_d = (state_d == S_END);
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        cpu_hold_d   = cpu_hold_q;
        frame_err_d  = 1'b0;
        if (state_d == S_WR) begin
            wr_addr_d = ptr_q;
        end else begin
            wr_addr_d = wr_addr_q;
        end
        if ((state_q == S_LO) && xfer_s) begin
            wr_data_d = {hi_q, in_data};
        end else begin
            wr_data_d = wr_data_q;
        end
        case (state_q)
            S_TGT: begin
                if (xfer_s && (in_data == 8'd0)) begin
                    cpu_hold_d = 1'b1;
                end else begin
                    cpu_hold_d = cpu_hold_q;
                end
                frame_err_d = xfer_s && (in_data[7:1] != 7'd0);
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: begin
                frame_err_d = xfer_s && (in_data != csum_q);
            end
`endif
            // Only a clean instruction frame releases the core
            S_END: begin
                if (!wr_sel_q) begin
                    cpu_hold_d = 1'b0;
                end else begin
                    cpu_hold_d = cpu_hold_q;
                end
            end
            default: begin
                cpu_hold_d  = cpu_hold_q;
                frame_err_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued as bytes are sent and popped on wr_en.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic        wr_sel;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cpu_hold;
    logic        frame_done;
    logic        frame_err;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic [24:0] exp_q[$];
    logic [7:0]  xsum;

    prog_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare every write and pulse against the model
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                chk("rdy_in_wr", {31'd0, in_ready}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_wr", {7'd0, wr_sel, wr_addr, wr_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("wr_word", {7'd0, wr_sel, wr_addr, wr_data}, {7'd0, exp_q.pop_front()});
                end
            end
            if (frame_done) begin
                done_cnt++;
                chk("rdy_in_end", {31'd0, in_ready}, 32'd0);
            end
            if (frame_err) err_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("rdy_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic sel, input logic [7:0] addr, input logic [15:0] w);
        exp_q.push_back({sel, addr, w});
        xsum = xsum ^ w[15:8] ^ w[7:0];
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic send_hdr(input logic [7:0] tgt, input logic [7:0] base, input logic [7:0] cnt);
        xsum = 8'd0;
        send_byte(8'hA5);
        send_byte(tgt);
        send_byte(base);
        send_byte(cnt);
    endtask

    task automatic send_csum(input logic [7:0] c);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(c);
`endif
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 8'd0;
        xsum = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {16'd0, wr_data}, 32'd0);
        chk("rst_pulses", {30'd0, frame_done, frame_err}, 32'd0);
        rst = 1'b0;

        // Basic instruction frame
        send_hdr(8'h00, 8'h10, 8'h02);
        send_word(1'b0, 8'h10, 16'h1234);
        send_word(1'b0, 8'h11, 16'hABCD);
        chk("csum_model", {24'd0, xsum}, 32'h40);
        send_csum(xsum);
        idle(4);
        chk("f1_done", done_cnt, 1);
        chk("f1_err", err_cnt, 0);
        chk("f1_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        chk("f1_sb_empty", exp_q.size(), 0);

        // Garbage then bad TARGET
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        send_byte(8'hA5);
        send_byte(8'h07);
        idle(3);
        chk("bad_tgt_err", err_cnt, 1);
        chk("bad_tgt_done", done_cnt, 1);
        chk("bad_tgt_hold", {31'd0, cpu_hold}, 32'd0);

        // Data frame with address wrap, then an instruction frame back-to-back
        send_hdr(8'h01, 8'hFF, 8'h02);
        send_word(1'b1, 8'hFF, 16'h1122);
        send_word(1'b1, 8'h00, 16'h3344);
        send_csum(xsum);
        xsum = 8'd0;
        send_byte(8'hA5);
        chk("data_done", done_cnt, 2);
        chk("data_hold", {31'd0, cpu_hold}, 32'd0);
        send_byte(8'h00);
        send_byte(8'h80);
        send_byte(8'h00);
        chk("full_hold_set", {31'd0, cpu_hold}, 32'd1);
        for (int i = 0; i < 256; i++) begin
            send_word(1'b0, 8'(8'h80 + i), {8'(i), ~8'(i)});
        end
        send_csum(xsum);
        idle(4);
        chk("full_done", done_cnt, 3);
        chk("full_hold_clr", {31'd0, cpu_hold}, 32'd0);
        chk("full_sb_empty", exp_q.size(), 0);
        chk("full_wr_addr_hold", {24'd0, wr_addr}, 32'h7F);

        // Reset mid-payload, then a clean frame
        send_hdr(8'h00, 8'h20, 8'h04);
        send_word(1'b0, 8'h20, 16'h5555);
        send_word(1'b0, 8'h21, 16'h6666);
        idle(1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_mid_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_mid_sb", exp_q.size(), 0);
        send_hdr(8'h00, 8'h30, 8'h01);
        send_word(1'b0, 8'h30, 16'hBEEF);
        send_csum(xsum);
        idle(4);
        chk("after_rst_done", done_cnt, 4);
        chk("after_rst_hold", {31'd0, cpu_hold}, 32'd0);
        chk("after_rst_sb", exp_q.size(), 0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Wrong checksum on an instruction frame
        send_hdr(8'h00, 8'h40, 8'h01);
        send_word(1'b0, 8'h40, 16'h1234);
        send_byte(xsum ^ 8'h26 ^ 8'h00 ^ 8'hFF);
        idle(4);
        chk("bad_csum_err", err_cnt, 2);
        chk("bad_csum_done", done_cnt, 4);
        chk("bad_csum_hold", {31'd0, cpu_hold}, 32'd1);
        chk("bad_csum_sb", exp_q.size(), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
